fetch_unit: RTL and testbench

Parametrised instruction-fetch stage of the single-issue core. Holds the program counter, reads a word-aligned, byte-addressed instruction memory with one-cycle latency, and hands instruction/PC pairs to decode over a valid/ready handshake. Supports stall, branch/jump redirect with flush, a program-load write port, and a sticky fault on misaligned or out-of-range fetch addresses.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a word-addressed instruction memory with one
// cycle of latency and presents instruction/PC pairs to decode over a valid/ready handshake.
// A misaligned or out-of-range fetch parks the unit in a sticky fault state until reset.
module fetch_unit #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     DEPTH    = 1024,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_pc,
  output logic [PC_W-1:0] out_pc4,
  output logic            fault,
  output logic [PC_W-1:0] fault_pc,
  input  logic            imem_we,
  input  logic [PC_W-1:0] imem_waddr,
  input  logic [31:0]     imem_wdata
);

  // Word-index width; clamped so a one-word memory still has a legal slice.
  localparam int unsigned     AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_W-1:0] DepthW = PC_W'(DEPTH);
  localparam logic [PC_W-1:0] Four   = PC_W'(4);

  typedef enum logic [0:0] {StRun, StFault} state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic            valid_q;
  logic [31:0]     inst_q;
  logic [PC_W-1:0] opc_q;
  logic [PC_W-1:0] opc4_q;
  logic            fault_q;
  logic [PC_W-1:0] fault_pc_q;

  logic [31:0]     mem_q [DEPTH];

  logic            advance;
  logic            fetch_bad;
  logic            waddr_ok;
  logic [PC_W-1:0] pc_plus4;
  logic [31:0]     fetch_word;
  logic            unused_waddr;

  // Byte-offset bits of the load address carry no information.
  assign unused_waddr = ^imem_waddr[1:0];

  // Decode the advance condition, the fetch-address check and the memory read port.
  always_comb begin
    advance    = (state_q == StRun) && !redirect && !stall && (!valid_q || out_ready);
    fetch_bad  = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[PC_W-1:2]} >= DepthW);
    waddr_ok   = {2'b00, imem_waddr[PC_W-1:2]} < DepthW;
    pc_plus4   = pc_q + Four;
    fetch_word = mem_q[pc_q[AW+1:2]];
  end

  // Program-load write port; out-of-range addresses are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (imem_we && waddr_ok) begin
      mem_q[imem_waddr[AW+1:2]] <= imem_wdata;
    end
  end

  // Fetch FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      inst_q     <= '0;
      opc_q      <= '0;
      opc4_q     <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      case (state_q)
        StRun: begin
          if (redirect) begin
            // Flush the word in flight; the target is range-checked when fetched.
            valid_q <= 1'b0;
            pc_q    <= redirect_pc;
          end else if (advance) begin
            if (fetch_bad) begin
              state_q    <= StFault;
              fault_q    <= 1'b1;
              fault_pc_q <= pc_q;
              valid_q    <= 1'b0;
            end else begin
              inst_q  <= fetch_word;
              opc_q   <= pc_q;
              opc4_q  <= pc_plus4;
              valid_q <= 1'b1;
              pc_q    <= pc_plus4;
            end
          end else if (valid_q && out_ready) begin
            // Decode took the word while stalled; nothing replaces it.
            valid_q <= 1'b0;
          end
        end
        StFault: begin
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= StFault;
        end
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_inst  = inst_q;
  assign out_pc    = opc_q;
  assign out_pc4   = opc4_q;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle tables for handshake/stall/redirect/write-collision behaviour,
// a scoreboard of words decode must accept in order, and hand sequences for fault and reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic        fault;
  logic [31:0] fault_pc;
  logic        imem_we = 1'b0;
  logic [31:0] imem_waddr = '0;
  logic [31:0] imem_wdata = '0;

  fetch_unit #(
    .PC_W    (32),
    .DEPTH   (16),
    .RESET_PC(32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .out_pc4    (out_pc4),
    .fault      (fault),
    .fault_pc   (fault_pc),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        we;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] golden [16];
  logic [63:0] sb_q [$];
  vec_t        vec_a [$];
  vec_t        vec_d [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                              input logic rd, input logic w, input logic ev,
                              input logic [31:0] epc, input logic [31:0] ei);
    vec_t v;
    v.stall = s;
    v.redir = r;
    v.rpc   = rp;
    v.ready = rd;
    v.we    = w;
    v.ev    = ev;
    v.epc   = epc;
    v.einst = ei;
    return v;
  endfunction

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst);
    sb_q.push_back({pc, inst});
  endtask

  // Drive one table row, let one edge pass, compare registered outputs.
  task automatic apply(input vec_t v, input string tag, input int idx);
    stall       = v.stall;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    out_ready   = v.ready;
    imem_we     = v.we;
    imem_waddr  = 32'h8;
    imem_wdata  = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    imem_we = 1'b0;
    check($sformatf("%s%0d_valid", tag, idx), 32'(out_valid), 32'(v.ev));
    check($sformatf("%s%0d_fault", tag, idx), 32'(fault), 32'h0);
    if (v.ev) begin
      check($sformatf("%s%0d_pc", tag, idx), out_pc, v.epc);
      check($sformatf("%s%0d_inst", tag, idx), out_inst, v.einst);
      check($sformatf("%s%0d_pc4", tag, idx), out_pc4, v.epc + 32'h4);
    end
  endtask

  // Scoreboard: every word decode actually takes must be the next expected one.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !redirect) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow_pc", out_pc, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("sb_pc", out_pc, e[63:32]);
        check("sb_inst", out_inst, e[31:0]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) golden[i] = 32'h1000_0000 + i * 32'h0001_0203;
    golden[0] = 32'h2004001b;
    golden[1] = 32'h00853020;
    golden[2] = 32'h00a43822;

    // Handshake, backpressure, stall-consume and redirect-under-stall sequence.
    vec_a.push_back(mk(0, 0, 0, 1, 0, 1, 32'h0, golden[0]));
    vec_a.push_back(mk(0, 0, 0, 1, 0, 1, 32'h4, golden[1]));
    vec_a.push_back(mk(0, 0, 0, 1, 0, 1, 32'h8, golden[2]));
    vec_a.push_back(mk(0, 1, 32'h4, 1, 0, 0, 0, 0));
    vec_a.push_back(mk(0, 0, 0, 1, 0, 1, 32'h4, golden[1]));
    for (int i = 0; i < 3; i++) vec_a.push_back(mk(0, 0, 0, 0, 0, 1, 32'h4, golden[1]));
    vec_a.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    vec_a.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    vec_a.push_back(mk(0, 0, 0, 1, 0, 1, 32'h8, golden[2]));
    vec_a.push_back(mk(0, 0, 0, 1, 0, 1, 32'hC, golden[3]));
    vec_a.push_back(mk(0, 1, 32'h4, 1, 0, 0, 0, 0));
    vec_a.push_back(mk(0, 0, 0, 1, 0, 1, 32'h4, golden[1]));
    vec_a.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    vec_a.push_back(mk(1, 1, 32'h20, 1, 0, 0, 0, 0));
    vec_a.push_back(mk(0, 0, 0, 1, 0, 1, 32'h20, golden[8]));
    vec_a.push_back(mk(0, 0, 0, 1, 0, 1, 32'h24, golden[9]));

    // Same-cycle write/fetch of word 0x8, then a refetch of it.
    vec_d.push_back(mk(0, 0, 0, 1, 0, 1, 32'h0, golden[0]));
    vec_d.push_back(mk(0, 0, 0, 1, 0, 1, 32'h4, golden[1]));
    vec_d.push_back(mk(0, 0, 0, 1, 1, 1, 32'h8, golden[2]));
    vec_d.push_back(mk(0, 0, 0, 1, 0, 1, 32'hC, golden[3]));
    vec_d.push_back(mk(0, 1, 32'h8, 1, 0, 0, 0, 0));
    vec_d.push_back(mk(0, 0, 0, 1, 0, 1, 32'h8, 32'hDEADBEEF));
    vec_d.push_back(mk(0, 0, 0, 0, 0, 1, 32'h8, 32'hDEADBEEF));

    // Load the program while held in reset; the 0x40 write is out of range.
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      imem_we    = 1'b1;
      imem_waddr = i * 4;
      imem_wdata = golden[i];
    end
    @(posedge clk);
    #1;
    imem_waddr = 32'h40;
    imem_wdata = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    imem_we = 1'b0;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_pc4", out_pc4, 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_fault_pc", fault_pc, 32'h0);

    // Words decode should take in phase A and the sequential run up to the fault.
    push_exp(32'h0, golden[0]);
    push_exp(32'h4, golden[1]);
    push_exp(32'h4, golden[1]);
    push_exp(32'h8, golden[2]);
    push_exp(32'h4, golden[1]);
    push_exp(32'h20, golden[8]);
    for (int a = 9; a < 16; a++) push_exp(a * 4, golden[a]);

    rst = 1'b0;
    foreach (vec_a[i]) apply(vec_a[i], "a", i);

    // Run off the end of the 16-word memory.
    stall     = 1'b0;
    redirect  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (fault) break;
    end
    check("range_fault", 32'(fault), 32'h1);
    check("range_fault_pc", fault_pc, 32'h40);
    check("range_valid", 32'(out_valid), 32'h0);
    check("range_sb_drained", sb_q.size(), 32'h0);

    // Redirects are ignored once faulted.
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    redirect = 1'b0;
    @(posedge clk);
    #1;
    check("fault_hold", 32'(fault), 32'h1);
    check("fault_hold_pc", fault_pc, 32'h40);
    check("fault_hold_valid", 32'(out_valid), 32'h0);

    // Misaligned redirect target faults on its fetch attempt.
    rst = 1'b1;
    #1;
    check("rst_clears_fault", 32'(fault), 32'h0);
    check("rst_clears_fault_pc", fault_pc, 32'h0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h22;
    @(posedge clk);
    #1;
    check("mis_redir_valid", 32'(out_valid), 32'h0);
    check("mis_redir_fault", 32'(fault), 32'h0);
    redirect = 1'b0;
    @(posedge clk);
    #1;
    check("mis_fault", 32'(fault), 32'h1);
    check("mis_fault_pc", fault_pc, 32'h22);
    check("mis_valid", 32'(out_valid), 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    redirect = 1'b0;
    check("mis_hold_fault", 32'(fault), 32'h1);
    check("mis_hold_pc", fault_pc, 32'h22);
    check("mis_hold_valid", 32'(out_valid), 32'h0);

    // Restart from reset, then the write/fetch collision table.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_exp(32'h0, golden[0]);
    push_exp(32'h4, golden[1]);
    push_exp(32'h8, golden[2]);
    foreach (vec_d[i]) apply(vec_d[i], "d", i);

    // Asynchronous reset clears a held valid word before any clock edge.
    #1;
    rst = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'h0);
    check("async_inst", out_inst, 32'h0);
    check("async_pc", out_pc, 32'h0);
    check("async_pc4", out_pc4, 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("restart_valid", 32'(out_valid), 32'h1);
    check("restart_pc", out_pc, 32'h0);
    check("restart_inst", out_inst, golden[0]);
    @(posedge clk);
    #1;
    check("sb_final_empty", sb_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
